// File: rtl/div7_pkg.sv
// Shared definitions for the div7 job feeder: sizes, the one-hot feeder
// state encoding and the error marker reported on a watchdog timeout.
package div7_pkg;

  localparam int DIV7_DEPTH = 16;
  localparam int DIV7_WIDTH = 8;

  // Result value reported when the engine never signals done.
  localparam logic [7:0] DIV7_ERR_MAX = 8'hFF;

  // One-hot feeder states.
  typedef enum logic [4:0] {
    FS_FILL   = 5'b00001,
    FS_START  = 5'b00010,
    FS_WAIT   = 5'b00100,
    FS_REPORT = 5'b01000,
    FS_ACK    = 5'b10000
  } fs_state_t;

  // True when a state vector has exactly one bit set.
  function automatic logic fs_is_onehot(input logic [4:0] s);
    return (s != 5'b00000) && ((s & (s - 5'b00001)) == 5'b00000);
  endfunction

endpackage

// File: rtl/div7_job_ram.sv
// Job storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module div7_job_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store one entry per accepted upstream beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/div7_job_feeder.sv
// div7_job_feeder: collects a DEPTH-entry job from an upstream stream, serves
// it to the largest-multiple-of-7 engine, runs the Start/Ack handshake and
// forwards the engine result on a downstream valid/ready stream.
// Optional feature macro: DIV7_FEEDER_TIMEOUT_EN (watchdog in WAIT that
// reports DIV7_ERR_MAX as an error marker after TIMEOUT_CYCLES).
module div7_job_feeder
  import div7_pkg::*;
#(
  parameter  int DEPTH          = DIV7_DEPTH,
  parameter  int WIDTH          = DIV7_WIDTH,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Din_valid,
  input  logic [WIDTH-1:0] Din_data,
  output logic             Din_ready,
  input  logic [AW-1:0]    Rd_addr,
  output logic [WIDTH-1:0] Rd_data,
  output logic             Start,
  output logic             Ack,
  input  logic             Qi,
  input  logic             Qdf,
  input  logic             Qdnf,
  input  logic [WIDTH-1:0] Max,
  output logic             Res_valid,
  output logic             Res_found,
  output logic [WIDTH-1:0] Res_max,
  input  logic             Res_ready
);

  localparam logic [AW-1:0] LAST_WP = AW'(DEPTH - 1);

  fs_state_t        state_r, state_next;
  logic [AW-1:0]    wp_r, wp_next;
  logic             wr_en;
  logic             start_r, ack_r, din_ready_r;
  logic             res_valid_r, res_found_r;
  logic [WIDTH-1:0] res_max_r;
  logic             rv_next, rf_next;
  logic [WIDTH-1:0] rm_next;
  logic             timeout_s;

  div7_job_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (Clk),
    .we    (wr_en),
    .waddr (wp_r),
    .wdata (Din_data),
    .raddr (Rd_addr),
    .rdata (Rd_data)
  );

`ifdef DIV7_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_r;

  // Watchdog: held at zero outside WAIT, counts each cycle spent in WAIT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_r <= '0;
    end else if (state_r != FS_WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + TW'(1);
    end
  end

  assign timeout_s = (state_r == FS_WAIT) && (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused_c = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // Next-state, write-pointer and result-register logic.
  always_comb begin
    state_next = state_r;
    wp_next    = wp_r;
    wr_en      = 1'b0;
    rv_next    = res_valid_r;
    rf_next    = res_found_r;
    rm_next    = res_max_r;
    case (state_r)
      FS_FILL: begin
        if (Din_valid && din_ready_r) begin
          wr_en   = 1'b1;
          wp_next = wp_r + AW'(1);
          if (wp_r == LAST_WP) begin
            state_next = FS_START;
          end else begin
            state_next = FS_FILL;
          end
        end else begin
          state_next = FS_FILL;
        end
      end
      FS_START: begin
        // Done flags seen here are picked up again once in WAIT.
        if (!Qi) begin
          state_next = FS_WAIT;
        end else begin
          state_next = FS_START;
        end
      end
      FS_WAIT: begin
        if (Qdf) begin
          rf_next    = 1'b1;
          rm_next    = Max;
          rv_next    = 1'b1;
          state_next = FS_REPORT;
        end else if (Qdnf) begin
          rf_next    = 1'b0;
          rm_next    = '0;
          rv_next    = 1'b1;
          state_next = FS_REPORT;
        end else if (timeout_s) begin
          rf_next    = 1'b0;
          rm_next    = WIDTH'(DIV7_ERR_MAX);
          rv_next    = 1'b1;
          state_next = FS_REPORT;
        end else begin
          state_next = FS_WAIT;
        end
      end
      FS_REPORT: begin
        if (res_valid_r && Res_ready) begin
          rv_next    = 1'b0;
          state_next = FS_ACK;
        end else begin
          state_next = FS_REPORT;
        end
      end
      FS_ACK: begin
        state_next = FS_FILL;
        wp_next    = '0;
      end
      default: begin
        state_next = FS_FILL;
        wp_next    = '0;
        rv_next    = 1'b0;
      end
    endcase
    if (!fs_is_onehot(state_r)) begin
      state_next = FS_FILL;
    end else begin
      state_next = state_next;
    end
  end

  // State, pointer and registered handshake outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= FS_FILL;
      wp_r        <= '0;
      start_r     <= 1'b0;
      ack_r       <= 1'b0;
      din_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_found_r <= 1'b0;
      res_max_r   <= '0;
    end else begin
      state_r     <= state_next;
      wp_r        <= wp_next;
      start_r     <= (state_next == FS_START);
      ack_r       <= (state_next == FS_ACK);
      din_ready_r <= (state_next == FS_FILL);
      res_valid_r <= rv_next;
      res_found_r <= rf_next;
      res_max_r   <= rm_next;
    end
  end

  assign Din_ready = din_ready_r;
  assign Start     = start_r;
  assign Ack       = ack_r;
  assign Res_valid = res_valid_r;
  assign Res_found = res_found_r;
  assign Res_max   = res_max_r;

endmodule

// File: doc/div7_job_feeder.md
Name: div7_job_feeder

Overview:
- Producer and initiator side of the team's largest-multiple-of-7 search engine.
- Collects a 16-entry job of unsigned bytes from an upstream valid/ready stream and serves the entries to the engine through a read port.
- Drives the engine's Start/Ack handshake, watches its one-hot done flags, captures the result, and hands it downstream on a second valid/ready stream.

Parameters:
DEPTH, 16, entries per job (power of 2; index width log2(DEPTH))
WIDTH, 8, bits per entry and per result
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with the optional feature)

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
Din_valid  in  1  upstream entry valid
Din_data  in  WIDTH  upstream entry
Din_ready  out  1  feeder accepts an entry this cycle
Rd_addr  in  4  engine read index
Rd_data  out  WIDTH  entry at Rd_addr, combinational
Start  out  1  to engine
Ack  out  1  to engine
Qi  in  1  engine in initial state
Qdf  in  1  engine done, found
Qdnf  in  1  engine done, not found
Max  in  WIDTH  engine result
Res_valid  out  1  result available downstream
Res_found  out  1  1 = a multiple was found, 0 = none
Res_max  out  WIDTH  captured Max; 0 when not found
Res_ready  in  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-low on Reset_n.
- Reset:
  - state = FILL, write pointer Wp = 0.
  - Start = 0, Ack = 0, Res_valid = 0, Res_found = 0, Res_max = 0.
  - Array contents are not reset.
- One-hot states: FILL, START, WAIT, REPORT, ACK.
- FILL:
  - Din_ready = 1.
  - On Din_valid & Din_ready: array[Wp] <= Din_data, Wp <= Wp + 1 (wraps to 0).
  - On the write where Wp == DEPTH-1, go to START.
  - Din_ready = 0 in every other state; upstream stalls.
- START:
  - Start = 1 (registered output, high throughout START).
  - Leave to WAIT on the first cycle Qi == 0 (engine has left its initial state).
  - If the engine is already done (Qdf | Qdnf) in that same cycle, still go to WAIT.
- WAIT:
  - Start = 0.
  - On Qdf: Res_found <= 1, Res_max <= Max.
  - On Qdnf: Res_found <= 0, Res_max <= 0.
  - Either flag sets Res_valid <= 1 and moves to REPORT.
  - Qdf and Qdnf both high is illegal; Qdf takes priority.
- REPORT:
  - Res_valid, Res_found and Res_max stay stable until Res_valid & Res_ready.
  - On that handshake: Res_valid <= 0, go to ACK.
- ACK:
  - Ack = 1 for exactly one cycle, then go to FILL with Wp = 0.
  - The engine returns to its initial state on that edge.
  - Minimum gap between two jobs is 16 fill cycles plus engine time.
- Rd_data:
  - Pure combinational array read, valid in all states.
  - Array is frozen outside FILL, so the engine always sees a stable job.
- Latency:
  - Last Din beat to Start high: 1 cycle.
  - Done flag to Res_valid: 1 cycle.
  - Res handshake to Ack: 1 cycle.
- Reset mid-job:
  - Feeder returns to FILL immediately; Start and Ack drop asynchronously.
  - Partial job is discarded.
  - The engine is reset by the same system reset.

Optional Feature:
- Macro: DIV7_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - At TIMEOUT_CYCLES with no done flag: Res_found <= 0, Res_max <= all ones (error marker), Res_valid <= 1, go to REPORT.
  - ACK then pulses Ack as normal.
- Undefined:
  - No counter; WAIT waits indefinitely.

Decomposition:
- Shared package div7_pkg holds:
  - state localparams FS_FILL, FS_START, FS_WAIT, FS_REPORT, FS_ACK (5-bit one-hot);
  - DIV7_DEPTH = 16 and DIV7_WIDTH = 8;
  - the error marker constant DIV7_ERR_MAX = 8'hFF.
- One natural sub-module: div7_job_ram, a DEPTH x WIDTH register array with one write port and one asynchronous read port.
- Control FSM stays in the top module.

Test Plan:
- Reset then no stimulus -> Din_ready = 1, Start = 0, Ack = 0, Res_valid = 0 for 20 cycles.
- Feed 16 bytes {3, 14, 49, 50, 21, 0, 7, 8, 63, 70, 5, 1, 2, 4, 6, 9} with the engine attached -> Start one cycle after the 16th beat; Res_found = 1, Res_max = 70; Ack one cycle after Res_ready.
- Feed 16 bytes {1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 15, 16, 17, 0} -> Res_found = 0, Res_max = 0.
- Hold Res_ready = 0 for 10 cycles after Res_valid -> Res_* stable; no Ack; Din_ready = 0. Then Res_ready = 1 -> Ack pulses 1 cycle, then FILL.
- Assert Reset_n low during WAIT -> Start and Ack = 0 immediately. Release and feed a new job -> correct result.
- With DIV7_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, done flags held low -> Res_valid on the 8th WAIT cycle, Res_found = 0, Res_max = 8'hFF.
